// File: rtl/train_sequencer.sv
// Training-sample sequencer: fetches each sample word, presents it for a fixed
// number of cycles, rests, and loops over the sample set for N epochs.
module train_sequencer #(
    parameter int NUM_SAMPLES = 999,
    parameter int ADDR_W      = 10,
    parameter int PRESENT_CYC = 4,
    parameter int REST_CYC    = 2,
    parameter int EPOCH_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    input  logic [EPOCH_W-1:0] num_epochs,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [6:0]         mem_rdata,
    output logic [6:0]         xout,
    output logic               xout_valid,
    output logic [ADDR_W-1:0]  sample_idx,
    output logic [EPOCH_W-1:0] epoch_idx,
    output logic               busy,
    output logic               done
);
    localparam int PH_MAX = (PRESENT_CYC > REST_CYC) ? PRESENT_CYC : REST_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, REST, DONE} state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [ADDR_W-1:0]  sidx_q, sidx_d;
    logic [EPOCH_W-1:0] eidx_q, eidx_d;
    logic [EPOCH_W-1:0] nep_q, nep_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [6:0]         xout_q, xout_d;
    logic               xvld_q, xvld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               advance, frozen;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sidx_d  = sidx_q;
        eidx_d  = eidx_q;
        nep_d   = nep_q;
        advance = 1'b0;
        frozen  = pause && (state_q == PRESENT || state_q == REST);

        case (state_q)
            IDLE: begin
                if (start) begin
                    nep_d   = (num_epochs == '0) ? EPOCH_W'(1) : num_epochs;
                    sidx_d  = '0;
                    eidx_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                phase_d = '0;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (!pause) begin
                    if (phase_q == PH_W'(PRESENT_CYC - 1)) begin
                        phase_d = '0;
                        if (REST_CYC == 0) advance = 1'b1;
                        else               state_d = REST;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            REST: begin
                if (!pause) begin
                    if (phase_q == PH_W'(REST_CYC - 1)) begin
                        phase_d = '0;
                        advance = 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Advance folds into the last PRESENT/REST cycle; no extra bubble.
        if (advance) begin
            if (sidx_q < ADDR_W'(NUM_SAMPLES - 1)) begin
                sidx_d  = sidx_q + 1'b1;
                state_d = FETCH;
            end else if (eidx_q < nep_q - EPOCH_W'(1)) begin
                eidx_d  = eidx_q + 1'b1;
                sidx_d  = '0;
                state_d = FETCH;
            end else begin
                state_d = DONE;
            end
        end

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            sidx_d  = '0;
            eidx_d  = '0;
            phase_d = '0;
        end

        // Outputs are registered, so they are derived from the next state.
        rd_en_d = (state_d == FETCH);
        addr_d  = (state_d == FETCH) ? sidx_d : '0;
        xout_d  = '0;
        if (state_d == PRESENT) xout_d = (state_q == WAIT) ? mem_rdata : xout_q;
        xvld_d  = (state_d == PRESENT) && !frozen;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            sidx_q  <= '0;
            eidx_q  <= '0;
            nep_q   <= EPOCH_W'(1);
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            xout_q  <= '0;
            xvld_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sidx_q  <= sidx_d;
            eidx_q  <= eidx_d;
            nep_q   <= nep_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            xout_q  <= xout_d;
            xvld_q  <= xvld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_rd_en  = rd_en_q;
    assign mem_addr   = addr_q;
    assign xout       = xout_q;
    assign xout_valid = xvld_q;
    assign sample_idx = sidx_q;
    assign epoch_idx  = eidx_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_train_sequencer.sv
// Scoreboard bench: instance 0 has REST_CYC=1, instance 1 has REST_CYC=0.
// Stimulus pushes expected fetches/words/done cycles; a negedge monitor checks them.
module tb_train_sequencer;
    typedef struct {
        int addr;
        int ep;
        int cyc;
    } fetch_t;

    logic       clk = 1'b0;
    logic       rst [2];
    logic       st  [2];
    logic       pz  [2];
    logic       ab  [2];
    logic [7:0] nep [2];
    logic       rd  [2];
    logic [9:0] addr[2];
    logic [6:0] rdata[2];
    logic [6:0] xo  [2];
    logic       xv  [2];
    logic [9:0] sidx[2];
    logic [7:0] eidx[2];
    logic       bsy [2];
    logic       dn  [2];

    logic [6:0] mem [3];
    int         cyc = 0;
    int         start_cyc[2];
    int         n_tests = 0;
    int         n_fail  = 0;
    fetch_t     fq[2][$];
    int         wq[2][$];
    int         dq[2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    train_sequencer #(.NUM_SAMPLES(3), .ADDR_W(10), .PRESENT_CYC(2), .REST_CYC(1), .EPOCH_W(8)) dut (
        .clk(clk), .reset(rst[0]), .start(st[0]), .pause(pz[0]), .abort(ab[0]),
        .num_epochs(nep[0]), .mem_rd_en(rd[0]), .mem_addr(addr[0]), .mem_rdata(rdata[0]),
        .xout(xo[0]), .xout_valid(xv[0]), .sample_idx(sidx[0]), .epoch_idx(eidx[0]),
        .busy(bsy[0]), .done(dn[0]));

    train_sequencer #(.NUM_SAMPLES(3), .ADDR_W(10), .PRESENT_CYC(2), .REST_CYC(0), .EPOCH_W(8)) dut0 (
        .clk(clk), .reset(rst[1]), .start(st[1]), .pause(pz[1]), .abort(ab[1]),
        .num_epochs(nep[1]), .mem_rd_en(rd[1]), .mem_addr(addr[1]), .mem_rdata(rdata[1]),
        .xout(xo[1]), .xout_valid(xv[1]), .sample_idx(sidx[1]), .epoch_idx(eidx[1]),
        .busy(bsy[1]), .done(dn[1]));

    // Sample memory: one-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (rd[i]) rdata[i] <= (addr[i] < 10'd3) ? mem[addr[i]] : 7'h00;
    end

    function automatic void chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd[i]) begin
                if (fq[i].size() == 0) chk($sformatf("fetch_unexpected%0d", i), 1, 0);
                else begin
                    fetch_t e;
                    e = fq[i].pop_front();
                    chk($sformatf("fetch_addr%0d", i), int'(addr[i]), e.addr);
                    chk($sformatf("fetch_sidx%0d", i), int'(sidx[i]), e.addr);
                    chk($sformatf("fetch_epoch%0d", i), int'(eidx[i]), e.ep);
                    chk($sformatf("fetch_cycle%0d", i), cyc - start_cyc[i] + 1, e.cyc);
                end
            end
            if (xv[i]) begin
                if (wq[i].size() == 0) chk($sformatf("valid_unexpected%0d", i), 1, 0);
                else chk($sformatf("xout%0d", i), int'(xo[i]), wq[i].pop_front());
            end
            if (dn[i]) begin
                if (dq[i].size() == 0) chk($sformatf("done_unexpected%0d", i), 1, 0);
                else chk($sformatf("done_cycle%0d", i), cyc - start_cyc[i] + 1, dq[i].pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input int i, input int a, input int ep, input int c);
        fetch_t e;
        e.addr = a; e.ep = ep; e.cyc = c;
        fq[i].push_back(e);
    endtask

    task automatic push_samples(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            wq[i].push_back(int'(mem[k % 3]));
            wq[i].push_back(int'(mem[k % 3]));
        end
    endtask

    task automatic go(input int i, input int eps);
        nep[i] = 8'(eps);
        st[i] = 1'b1;
        start_cyc[i] = cyc;
        tick(1);
        st[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input string nm);
        int n = 0;
        while (bsy[i] && n < 300) begin
            tick(1);
            n++;
        end
        chk({nm, "_finished"}, int'(bsy[i]), 0);
    endtask

    task automatic chk_zero(input int i, input string nm);
        chk({nm, "_rd_en"}, int'(rd[i]), 0);
        chk({nm, "_addr"}, int'(addr[i]), 0);
        chk({nm, "_xout"}, int'(xo[i]), 0);
        chk({nm, "_valid"}, int'(xv[i]), 0);
        chk({nm, "_sidx"}, int'(sidx[i]), 0);
        chk({nm, "_eidx"}, int'(eidx[i]), 0);
        chk({nm, "_busy"}, int'(bsy[i]), 0);
        chk({nm, "_done"}, int'(dn[i]), 0);
    endtask

    task automatic chk_drained(input int i, input string nm);
        chk({nm, "_fetch_left"}, fq[i].size(), 0);
        chk({nm, "_words_left"}, wq[i].size(), 0);
        chk({nm, "_done_left"}, dq[i].size(), 0);
    endtask

    task automatic run_one_epoch(input int eps, input string nm);
        push_fetch(0, 0, 0, 2);
        push_fetch(0, 1, 0, 7);
        push_fetch(0, 2, 0, 12);
        push_samples(0, 3);
        dq[0].push_back(17);
        go(0, eps);
        wait_idle(0, nm);
        chk({nm, "_final_sidx"}, int'(sidx[0]), 2);
        chk({nm, "_final_eidx"}, int'(eidx[0]), 0);
        chk_drained(0, nm);
    endtask

    initial begin
        mem[0] = 7'h41; mem[1] = 7'h12; mem[2] = 7'h7F;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; st[i] = 1'b0; pz[i] = 1'b0; ab[i] = 1'b0; nep[i] = 8'd1;
            start_cyc[i] = 0;
        end
        tick(2);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick(1);

        // One epoch, then num_epochs=0 behaves identically.
        run_one_epoch(1, "ep1");
        tick(2);
        run_one_epoch(0, "ep0");
        tick(2);

        // Two epochs: period 5, done at 2*15+2.
        for (int e = 0; e < 2; e++)
            for (int s = 0; s < 3; s++)
                push_fetch(0, s, e, 2 + 5 * (3 * e + s));
        push_samples(0, 6);
        dq[0].push_back(32);
        go(0, 2);
        wait_idle(0, "ep2");
        chk("ep2_final_eidx", int'(eidx[0]), 1);
        chk_drained(0, "ep2");
        tick(2);

        // Pause for 3 cycles from the first PRESENT cycle of sample 1.
        push_fetch(0, 0, 0, 2);
        push_fetch(0, 1, 0, 7);
        push_fetch(0, 2, 0, 15);
        push_samples(0, 3);
        dq[0].push_back(20);
        go(0, 1);
        tick(7);
        pz[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("pause_valid_low", int'(xv[0]), 0);
            chk("pause_xout_held", int'(xo[0]), 'h12);
        end
        pz[0] = 1'b0;
        wait_idle(0, "pause");
        chk_drained(0, "pause");
        tick(2);

        // Abort in REST of sample 1, then a clean restart.
        push_fetch(0, 0, 0, 2);
        push_fetch(0, 1, 0, 7);
        push_samples(0, 2);
        go(0, 1);
        tick(9);
        ab[0] = 1'b1;
        tick(1);
        ab[0] = 1'b0;
        chk_zero(0, "abort");
        tick(3);
        chk_drained(0, "abort");
        run_one_epoch(1, "restart");
        tick(2);

        // REST_CYC=0 instance: reset during WAIT, then back-to-back samples.
        push_fetch(1, 0, 0, 2);
        go(1, 1);
        tick(1);
        rst[1] = 1'b1;
        tick(1);
        chk_zero(1, "midreset");
        rst[1] = 1'b0;
        tick(1);
        chk_drained(1, "midreset");
        push_fetch(1, 0, 0, 2);
        push_fetch(1, 1, 0, 6);
        push_fetch(1, 2, 0, 10);
        for (int k = 0; k < 3; k++) begin
            wq[1].push_back(int'(mem[k]));
            wq[1].push_back(int'(mem[k]));
        end
        dq[1].push_back(14);
        go(1, 1);
        wait_idle(1, "rest0");
        chk_drained(1, "rest0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
